pipe_stage_reg: RTL and testbench

- Generic, parametrised pipeline stage register for the OpenMIPS-class five-stage core.
- Replaces hand-written per-stage latches (ex/mem, mem/wb) with one block.
- Provides:
  - payload capture;
  - bubble injection under the global stall vector;
  - exception flush;
  - pass-through holding of multi-cycle execution state (accumulator temp + cycle count) across stalls.
- Instantiated between adjacent stages; STAGE selects its slice of the stall vector.

---
 rtl/pipe_stage_reg_pkg.sv | 9 +
 rtl/pipe_perf_cnt.sv | 19 +
 rtl/pipe_stage_reg.sv | 94 +++++++++
 tb/tb_pipe_stage_reg.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// rtl/pipe_stage_reg_pkg.sv - shared pipeline control encodings for stage registers
package pipe_stage_reg_pkg;

    localparam logic STOP          = 1'b1;
    localparam logic NOSTOP        = 1'b0;
    localparam logic RST_ENABLE    = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

endpackage

// File: rtl/pipe_perf_cnt.sv
// rtl/pipe_perf_cnt.sv - saturating event counter with synchronous clear
module pipe_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - generic pipeline stage register; PIPE_STAGE_PERF_EN adds bubble/hold counters
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int STALL_W         = 6,
    parameter int STAGE           = 3,
    parameter int NWE             = 4,
    parameter int DATA_W          = 160,
    parameter int MC_W            = 66,
    parameter bit BUBBLE_CLR_DATA = 1'b1,
    parameter int CNT_W           = 32
) (
    input  logic               clk,
    input  logic               Rst_n,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [NWE-1:0]     in_we,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [MC_W-1:0]    mc_state_i,
    output logic               out_valid,
    output logic [NWE-1:0]     out_we,
    output logic [DATA_W-1:0]  out_data,
    output logic [MC_W-1:0]    mc_state_o,
    output logic [CNT_W-1:0]   bubble_cnt_o,
    output logic [CNT_W-1:0]   hold_cnt_o
);

    // Shift rather than index so the whole stall vector is consumed.
    logic [1:0] stall_pair;
    logic       s_stop;
    logic       d_stop;

    assign stall_pair = 2'(stall >> STAGE);
    assign s_stop     = (stall_pair[0] == STOP);
    assign d_stop     = (stall_pair[1] == STOP);

    always_ff @(posedge clk) begin
        if (Rst_n == RST_ENABLE) begin
            out_valid  <= 1'b0;
            out_we     <= {NWE{WRITE_DISABLE}};
            out_data   <= '0;
            mc_state_o <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            out_we     <= {NWE{WRITE_DISABLE}};
            out_data   <= '0;
            mc_state_o <= '0;
        end else if (s_stop && !d_stop) begin
            out_valid  <= 1'b0;
            out_we     <= {NWE{WRITE_DISABLE}};
            if (BUBBLE_CLR_DATA) begin
                out_data <= '0;
            end
            mc_state_o <= mc_state_i;
        end else if (!s_stop) begin
            // in_we is captured unmasked even when in_valid is low.
            out_valid  <= in_valid;
            out_we     <= in_we;
            out_data   <= in_data;
            mc_state_o <= '0;
        end else begin
            mc_state_o <= mc_state_i;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic cnt_clr;
    logic bubble_inc;
    logic hold_inc;

    assign cnt_clr    = (Rst_n == RST_ENABLE);
    assign bubble_inc = !flush && s_stop && !d_stop;
    assign hold_inc   = !flush && s_stop && d_stop;

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk (clk),
        .clr (cnt_clr),
        .inc (bubble_inc),
        .cnt (bubble_cnt_o)
    );

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_hold_cnt (
        .clk (clk),
        .clr (cnt_clr),
        .inc (hold_inc),
        .cnt (hold_cnt_o)
    );
`else
    assign bubble_cnt_o = '0;
    assign hold_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg (two configurations)
module tb_pipe_stage_reg;

    localparam int STALL_W = 6;
    localparam int STAGE   = 3;
    localparam int NWE     = 4;
    localparam int DATA_W  = 160;
    localparam int MC_W    = 66;
    localparam int CNT_W   = 32;
    localparam int CNT1_W  = 4;
`ifdef PIPE_STAGE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic               in_valid;
    logic [NWE-1:0]     in_we;
    logic [DATA_W-1:0]  in_data;
    logic [MC_W-1:0]    mc_in;

    logic               v0, v1;
    logic [NWE-1:0]     we0, we1;
    logic [DATA_W-1:0]  d0, d1;
    logic [MC_W-1:0]    mc0, mc1;
    logic [CNT_W-1:0]   bc0, hc0;
    logic [CNT1_W-1:0]  bc1, hc1;

    pipe_stage_reg u0 (
        .clk(clk), .Rst_n(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_we(in_we), .in_data(in_data), .mc_state_i(mc_in),
        .out_valid(v0), .out_we(we0), .out_data(d0), .mc_state_o(mc0),
        .bubble_cnt_o(bc0), .hold_cnt_o(hc0)
    );

    pipe_stage_reg #(.BUBBLE_CLR_DATA(1'b0), .CNT_W(CNT1_W)) u1 (
        .clk(clk), .Rst_n(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_we(in_we), .in_data(in_data), .mc_state_i(mc_in),
        .out_valid(v1), .out_we(we1), .out_data(d1), .mc_state_o(mc1),
        .bubble_cnt_o(bc1), .hold_cnt_o(hc1)
    );

    typedef struct packed {
        logic              v;
        logic [NWE-1:0]    we;
        logic [DATA_W-1:0] d0;
        logic [DATA_W-1:0] d1;
        logic [MC_W-1:0]   mc;
        logic [CNT_W-1:0]  b0;
        logic [CNT_W-1:0]  h0;
        logic [CNT1_W-1:0] b1;
        logic [CNT1_W-1:0] h1;
    } exp_t;

    exp_t m = '0;
    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic fl, input logic [STALL_W-1:0] st,
                        input logic iv, input logic [NWE-1:0] iw,
                        input logic [DATA_W-1:0] id, input logic [MC_W-1:0] imc);
        assert (!(st[STAGE] == 1'b0 && st[STAGE+1] == 1'b1))
            else $error("illegal stall combination issued");
        rst = r; flush = fl; stall = st; in_valid = iv; in_we = iw; in_data = id; mc_in = imc;
        if (r) begin
            m = '0;
        end else if (fl) begin
            m.v = 1'b0; m.we = '0; m.d0 = '0; m.d1 = '0; m.mc = '0;
        end else if (st[STAGE] && !st[STAGE+1]) begin
            m.v = 1'b0; m.we = '0; m.d0 = '0; m.mc = imc;
            if (PERF) begin
                if (m.b0 != {CNT_W{1'b1}}) m.b0 = m.b0 + 1;
                if (m.b1 < 15) m.b1 = m.b1 + 1;
            end
        end else if (!st[STAGE]) begin
            m.v = iv; m.we = iw; m.d0 = id; m.d1 = id; m.mc = '0;
        end else begin
            m.mc = imc;
            if (PERF) begin
                if (m.h0 != {CNT_W{1'b1}}) m.h0 = m.h0 + 1;
                if (m.h1 < 15) m.h1 = m.h1 + 1;
            end
        end
        q.push_back(m);
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("valid0", DATA_W'(v0), DATA_W'(e.v));
                check("we0", DATA_W'(we0), DATA_W'(e.we));
                check("data0", d0, e.d0);
                check("mc0", DATA_W'(mc0), DATA_W'(e.mc));
                check("bcnt0", DATA_W'(bc0), DATA_W'(e.b0));
                check("hcnt0", DATA_W'(hc0), DATA_W'(e.h0));
                check("valid1", DATA_W'(v1), DATA_W'(e.v));
                check("we1", DATA_W'(we1), DATA_W'(e.we));
                check("data1", d1, e.d1);
                check("mc1", DATA_W'(mc1), DATA_W'(e.mc));
                check("bcnt1", DATA_W'(bc1), DATA_W'(e.b1));
                check("hcnt1", DATA_W'(hc1), DATA_W'(e.h1));
            end
        end
    end

    initial begin
        logic [STALL_W-1:0] st;
        logic [DATA_W-1:0]  rd;
        logic [MC_W-1:0]    rm;
        int                 r;
        int                 kind;

        step(1, 0, '0, 1, 4'hF, '1, '1);
        step(1, 0, '0, 1, 4'hF, '1, '1);
        step(0, 0, '0, 1, 4'hF, '1, '0);

        step(0, 0, 6'b001000, 1, 4'hF, 160'h99, 66'h3_0000_0001_0000_0002);
        step(0, 0, '0, 1, 4'h3, 160'h1234, 66'h5);

        step(0, 0, '0, 1, 4'h1, 160'hABCD, '0);
        for (int i = 0; i < 3; i++) begin
            rm = MC_W'({$urandom, $urandom, $urandom});
            step(0, 0, 6'b011000, 0, 4'h0, 160'h0, rm);
        end

        step(0, 1, 6'b001000, 1, 4'hF, 160'h77, 66'h1);
        step(0, 1, '0, 1, 4'hF, 160'h88, '0);

        step(0, 0, '0, 1, 4'h2, 160'h55, '0);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 6'b001000, 1, 4'hF, 160'h66, MC_W'(i));
        end
        step(1, 0, '0, 0, 4'h0, '0, '0);

        for (int i = 0; i < 2000; i++) begin
            r    = int'($urandom_range(0, 99));
            kind = int'($urandom_range(0, 2));
            st   = STALL_W'($urandom);
            st[STAGE]   = (kind != 0);
            st[STAGE+1] = (kind == 2);
            rd = {$urandom, $urandom, $urandom, $urandom, $urandom};
            rm = MC_W'({$urandom, $urandom, $urandom});
            step(r < 3, (r >= 3) && (r < 13), st, 1'($urandom), NWE'($urandom), rd, rm);
        end

        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        #5;
        if (q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
